bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 256, max cycles one requester may hold the grant (timeout build only).
REQ-002 SHALL have parameter CNT_BIT, default 16, width of the hold counter.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req1 / req2  in  1  requester holds high for the whole burst.
REQ-006 SHALL have ports BRAM_in1_en / BRAM_in2_en  in  1  requester access enables.
REQ-007 SHALL have ports BRAM_in1_wen / BRAM_in2_wen  in  4  requester byte write enables.
REQ-008 SHALL have ports gnt1 / gnt2  out  1  registered grants, never both high.
REQ-009 SHALL have port sel  out  1  port-mux select, 0 = requester 1, 1 = requester 2.
REQ-010 SHALL have ports rd_valid1 / rd_valid2  out  1  BRAM read data valid for that requester.
REQ-011 SHALL have port err  out  1  sticky protocol-error flag.
REQ-012 SHALL have port timeout  out  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT1, GRANT2, RELEASE; gnt1 high only in GRANT1, gnt2 only in GRANT2.
REQ-014 In IDLE or RELEASE: only req1 -> GRANT1; only req2 -> GRANT2; both -> grant the requester not in last_owner; neither -> IDLE.
REQ-015 last_owner SHALL update on every entry to GRANTx.
REQ-016 Grant latency SHALL be one cycle: req sampled high at edge n in IDLE gives gnt high from cycle n+1.
REQ-017 GRANTx with reqx sampled low SHALL go to RELEASE; gntx is low the cycle after req drops.
REQ-018 RELEASE SHALL last exactly one cycle with no grant, to drain the final BRAM access.
REQ-019 Handover SHALL take two cycles: req1 low at n gives gnt1 low at n+1 and gnt2 high at n+2.
REQ-020 sel SHALL change only on entry to GRANTx, and SHALL hold its last value in IDLE and RELEASE.
REQ-021 rd_validx SHALL be a registered copy of (gntx & BRAM_inx_en & BRAM_inx_wen==0), i.e. one cycle after the read is issued.
REQ-022 rd_validx SHALL be produced for a read issued in the last granted cycle even though gnt is already low.
REQ-023 err SHALL set when BRAM_inx_en is high while gntx is low, and SHALL stay high until rst.
REQ-024 A req that rises and falls while the other requester owns the grant SHALL be lost, with no grant issued for it.

Reset
REQ-025 rst high at an edge SHALL force IDLE, gnt1=gnt2=0, sel=0, rd_valid1=rd_valid2=0, err=0, timeout=0, counter=0, last_owner=2, blocked flags clear.
REQ-026 Mid-burst rst SHALL drop the grant on the next edge, and no rd_valid SHALL follow it.
REQ-027 After reset, req1 SHALL win the first tie.

Configuration
REQ-028 With BRAM_ARB_TIMEOUT_EN defined: the hold counter SHALL clear on GRANTx entry and increment each GRANTx cycle.
REQ-029 With BRAM_ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 with reqx still high:
- the FSM SHALL go to RELEASE;
- timeout SHALL pulse for one cycle;
- blockedx SHALL set.
REQ-030 With BRAM_ARB_TIMEOUT_EN defined, reqx SHALL be ignored while blockedx is set; blockedx SHALL clear when reqx is sampled low.
REQ-031 Without BRAM_ARB_TIMEOUT_EN: no counter or blocked logic, timeout tied 0, grant held while req is high.

Verification
REQ-032 Single requester: rst, then req1=1 at cycle 0 -> gnt1=1 and sel=0 at cycle 1; req1=0 at cycle 5 -> gnt1=0 at cycle 6.
REQ-033 Tie after reset: req1=req2=1 at cycle 0 -> gnt1 at cycle 1.
REQ-034 Tie handover: after REQ-033, drop req1 at cycle 4 -> gnt2=1 and sel=1 at cycle 6; a second tie goes to requester 1.
REQ-035 Read valid: gnt1, en1=1, wen1=0 at cycle 3 -> rd_valid1=1 at cycle 4 only; wen1=4'hF instead -> no rd_valid1.
REQ-036 Protocol error: en2=1 while gnt2=0 -> err=1 next cycle and held until rst.
REQ-037 Timeout build, MAX_HOLD=8: req1 held high -> gnt1 for 8 cycles, then timeout pulse; req2 pending gets gnt2 in the following cycle; req1 not regranted until it drops.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a shared BRAM port.
// Grants are registered, bursts are released through a one-cycle RELEASE
// state so the last BRAM access drains before the mux flips, and ties go to
// the requester that did not own the port last.
// Optional build macro BRAM_ARB_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD granted cycles and blocks the offender until it
// drops its request.
module bram_arbiter #(
    parameter int MAX_HOLD = 256,
    parameter int CNT_BIT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       BRAM_in1_en,
    input  logic       BRAM_in2_en,
    input  logic [3:0] BRAM_in1_wen,
    input  logic [3:0] BRAM_in2_wen,
    output logic       gnt1,
    output logic       gnt2,
    output logic       sel,
    output logic       rd_valid1,
    output logic       rd_valid2,
    output logic       err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // The hold counter must be able to represent MAX_HOLD-1.
    if (MAX_HOLD < 1 || $clog2(MAX_HOLD) > CNT_BIT) begin : g_param_check
        $error("bram_arbiter: CNT_BIT too narrow for MAX_HOLD");
    end

    state_t state;
    logic   last_owner;   // 0 = requester 1 owned last, 1 = requester 2
    logic   req1_eff;
    logic   req2_eff;
    logic   pick1;
    logic   pick2;

`ifdef BRAM_ARB_TIMEOUT_EN
    logic [CNT_BIT-1:0] hold_cnt;
    logic               blocked1;
    logic               blocked2;

    // A requester that was forced off is ignored until it lets go.
    assign req1_eff = req1 & ~blocked1;
    assign req2_eff = req2 & ~blocked2;
`else
    assign req1_eff = req1;
    assign req2_eff = req2;
    assign timeout  = 1'b0;
`endif

    // Tie goes to whoever did not own the port last.
    assign pick1 = req1_eff & (~req2_eff | last_owner);
    assign pick2 = req2_eff & ~pick1;

    // Arbitration FSM with registered grant, select and timeout outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt1       <= 1'b0;
            gnt2       <= 1'b0;
            sel        <= 1'b0;
            last_owner <= 1'b1;
`ifdef BRAM_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            blocked1   <= 1'b0;
            blocked2   <= 1'b0;
            timeout    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge values of state and the blocked flags.
`ifdef BRAM_ARB_TIMEOUT_EN
            timeout <= 1'b0;
            if (blocked1 && !req1) blocked1 <= 1'b0;
            if (blocked2 && !req2) blocked2 <= 1'b0;
`endif
            case (state)
                GRANT1: begin
                    if (!req1) begin
                        state <= RELEASE;
                        gnt1  <= 1'b0;
                    end
`ifdef BRAM_ARB_TIMEOUT_EN
                    else if (hold_cnt == CNT_BIT'(MAX_HOLD - 1)) begin
                        state    <= RELEASE;
                        gnt1     <= 1'b0;
                        timeout  <= 1'b1;
                        blocked1 <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                GRANT2: begin
                    if (!req2) begin
                        state <= RELEASE;
                        gnt2  <= 1'b0;
                    end
`ifdef BRAM_ARB_TIMEOUT_EN
                    else if (hold_cnt == CNT_BIT'(MAX_HOLD - 1)) begin
                        state    <= RELEASE;
                        gnt2     <= 1'b0;
                        timeout  <= 1'b1;
                        blocked2 <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    // IDLE and RELEASE arbitrate identically.
                    if (pick1) begin
                        state      <= GRANT1;
                        gnt1       <= 1'b1;
                        sel        <= 1'b0;
                        last_owner <= 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end else if (pick2) begin
                        state      <= GRANT2;
                        gnt2       <= 1'b1;
                        sel        <= 1'b1;
                        last_owner <= 1'b1;
`ifdef BRAM_ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Read-valid pipeline and sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid1 <= gnt1 & BRAM_in1_en & (BRAM_in1_wen == 4'h0);
            rd_valid2 <= gnt2 & BRAM_in2_en & (BRAM_in2_wen == 4'h0);
            if ((BRAM_in1_en & ~gnt1) | (BRAM_in2_en & ~gnt2)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus a randomized
// run against an ownership-level reference model.
module tb_bram_arbiter;

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 8;
`else
    localparam int TB_MAX_HOLD = 256;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0;
    logic [3:0] wen1 = 4'h0, wen2 = 4'h0;
    logic       gnt1, gnt2, sel, rd_valid1, rd_valid2, err, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .CNT_BIT(16)) dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .BRAM_in1_en(en1), .BRAM_in2_en(en2),
        .BRAM_in1_wen(wen1), .BRAM_in2_wen(wen2),
        .gnt1(gnt1), .gnt2(gnt2), .sel(sel),
        .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
        .err(err), .timeout(timeout)
    );

    // Reference model: who owns the port (0 = nobody), who owned it last,
    // how long the owner has held it, and the delayed/sticky side outputs.
    int m_owner = 0, m_last = 2, m_hold = 0;
    bit m_sel = 0, m_rdv1 = 0, m_rdv2 = 0, m_err = 0, m_to = 0;
    bit m_blk1 = 0, m_blk2 = 0;

    task automatic model_edge();
        bit g1, g2, a1, a2;
        int win;
        if (rst) begin
            m_owner = 0; m_last = 2; m_hold = 0; m_sel = 0;
            m_rdv1 = 0; m_rdv2 = 0; m_err = 0; m_to = 0;
            m_blk1 = 0; m_blk2 = 0;
        end else begin
            g1 = (m_owner == 1);
            g2 = (m_owner == 2);
            m_rdv1 = g1 && en1 && (wen1 == 4'h0);
            m_rdv2 = g2 && en2 && (wen2 == 4'h0);
            if ((en1 && !g1) || (en2 && !g2)) m_err = 1;
            m_to = 0;
            a1 = req1 && !m_blk1;
            a2 = req2 && !m_blk2;
            if (m_blk1 && !req1) m_blk1 = 0;
            if (m_blk2 && !req2) m_blk2 = 0;
            if (m_owner != 0) begin
                if (!((m_owner == 1) ? req1 : req2)) m_owner = 0;
`ifdef BRAM_ARB_TIMEOUT_EN
                else if (m_hold == TB_MAX_HOLD - 1) begin
                    if (m_owner == 1) m_blk1 = 1; else m_blk2 = 1;
                    m_to = 1;
                    m_owner = 0;
                end else m_hold++;
`endif
            end else begin
                win = 0;
                if (a1 && a2) win = (m_last == 1) ? 2 : 1;
                else if (a1) win = 1;
                else if (a2) win = 2;
                if (win != 0) begin
                    m_owner = win; m_last = win; m_sel = (win == 2); m_hold = 0;
                end
            end
        end
    endtask

    // Advance one clock: update the model with the inputs the DUT samples,
    // then land 1 ns after the edge where outputs are stable.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1; req1 = 0; req2 = 0; en1 = 0; en2 = 0; wen1 = 0; wen2 = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        apply_reset();
        got = {gnt1, gnt2, sel, rd_valid1, rd_valid2, err, timeout};
        checks++;
        if (got !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req1 = 1;
        tick();  // cycle 1
        checks++;
        if (gnt1 !== 1'b1 || sel !== 1'b0 || gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL single_grant gnt1=%b sel=%b gnt2=%b exp 1 0 0", gnt1, sel, gnt2);
        end
        repeat (4) tick();  // cycle 5
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL single_hold gnt1=%b exp 1", gnt1);
        end
        req1 = 0;
        tick();  // cycle 6
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_release gnt1=%b exp 0", gnt1);
        end
        tick();
    endtask

    task automatic test_tie();
        apply_reset();
        req1 = 1; req2 = 1;
        tick();  // cycle 1
        checks++;
        if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL first_tie gnt1=%b gnt2=%b exp 1 0", gnt1, gnt2);
        end
        repeat (3) tick();  // cycle 4
        req1 = 0;
        tick();  // cycle 5
        checks++;
        if (gnt1 !== 1'b0 || gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL handover_gap gnt1=%b gnt2=%b exp 0 0", gnt1, gnt2);
        end
        tick();  // cycle 6
        checks++;
        if (gnt2 !== 1'b1 || sel !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL handover_grant gnt2=%b sel=%b gnt1=%b exp 1 1 0", gnt2, sel, gnt1);
        end
        req1 = 1;
        tick();  // cycle 7
        req2 = 0;
        tick();  // cycle 8, release
        req2 = 1;
        tick();  // cycle 9
        checks++;
        if (gnt1 !== 1'b1 || sel !== 1'b0 || gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL second_tie gnt1=%b sel=%b gnt2=%b exp 1 0 0", gnt1, sel, gnt2);
        end
        req1 = 0; req2 = 0;
        repeat (2) tick();
    endtask

    task automatic test_read_valid();
        apply_reset();
        req1 = 1;
        repeat (3) tick();  // cycle 3
        en1 = 1; wen1 = 4'h0;
        tick();  // cycle 4
        checks++;
        if (rd_valid1 !== 1'b1 || rd_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL read_valid rd_valid1=%b rd_valid2=%b exp 1 0", rd_valid1, rd_valid2);
        end
        en1 = 0;
        tick();
        checks++;
        if (rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL read_valid_single rd_valid1=%b exp 0", rd_valid1);
        end
        en1 = 1; wen1 = 4'hF;
        tick();
        checks++;
        if (rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL write_no_valid rd_valid1=%b exp 0", rd_valid1);
        end
        // Read in the final granted cycle still produces a valid.
        wen1 = 4'h0; req1 = 0;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || gnt1 !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL last_cycle_read rd_valid1=%b gnt1=%b err=%b exp 1 0 0", rd_valid1, gnt1, err);
        end
        en1 = 0;
        repeat (2) tick();
    endtask

    task automatic test_lost_request();
        apply_reset();
        req1 = 1;
        repeat (3) tick();
        req2 = 1;
        repeat (2) tick();
        req2 = 0;
        repeat (2) tick();
        req1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt2 !== 1'b0) begin
                errors++;
                $display("FAIL lost_request step=%0d gnt2=%b exp 0", i, gnt2);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] got, exp;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) req1 = ~req1;
            if ($urandom_range(0, 5) == 0) req2 = ~req2;
            en1  = (m_owner == 1) && ($urandom_range(0, 1) == 1);
            en2  = (m_owner == 2) && ($urandom_range(0, 1) == 1);
            wen1 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            wen2 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            tick();
            got = {gnt1, gnt2, sel, rd_valid1, rd_valid2, err, timeout};
            exp = {m_owner == 1, m_owner == 2, m_sel, m_rdv1, m_rdv2, m_err, m_to};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle=%0d got=%b exp=%b (gnt1 gnt2 sel rdv1 rdv2 err to)",
                         i, got, exp);
            end
        end
        req1 = 0; req2 = 0; en1 = 0; en2 = 0;
        repeat (3) tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req1 = 1;
        repeat (2) tick();
        en1 = 1; wen1 = 4'h0; rst = 1;
        tick();
        checks++;
        if (gnt1 !== 1'b0 || rd_valid1 !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_drop gnt1=%b rd_valid1=%b sel=%b exp 0 0 0", gnt1, rd_valid1, sel);
        end
        rst = 0; en1 = 0; req1 = 0;
        tick();
        checks++;
        if (rd_valid1 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_valid rd_valid1=%b gnt1=%b exp 0 0", rd_valid1, gnt1);
        end
    endtask

    task automatic test_protocol_error();
        apply_reset();
        en2 = 1;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set err=%b exp 1", err);
        end
        en2 = 0;
        repeat (5) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b exp 1", err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared err=%b exp 0", err);
        end
    endtask

`ifdef BRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req1 = 1;
        tick();  // cycle 1
        req2 = 1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (gnt1 !== 1'b1 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cycle=%0d gnt1=%b timeout=%b exp 1 0", k, gnt1, timeout);
            end
            tick();
        end
        checks++;  // cycle 9
        if (gnt1 !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse gnt1=%b timeout=%b exp 0 1", gnt1, timeout);
        end
        tick();  // cycle 10
        checks++;
        if (gnt2 !== 1'b1 || sel !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next gnt2=%b sel=%b timeout=%b exp 1 1 0", gnt2, sel, timeout);
        end
        req2 = 0;
        repeat (2) tick();  // cycle 12
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_blocked gnt1=%b exp 0", gnt1);
        end
        req1 = 0;
        tick();
        req1 = 1;
        tick();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_unblocked gnt1=%b exp 1", gnt1);
        end
        req1 = 0;
        repeat (2) tick();
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        req1 = 1;
        tick();
        req2 = 1;
        for (int k = 0; k < TB_MAX_HOLD + 40; k++) begin
            tick();
            checks++;
            if (gnt1 !== 1'b1 || gnt2 !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL long_hold cycle=%0d gnt1=%b gnt2=%b timeout=%b exp 1 0 0",
                         k, gnt1, gnt2, timeout);
            end
        end
        req1 = 0; req2 = 0;
        repeat (2) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_read_valid();
        test_lost_request();
        test_random();
        test_mid_reset();
        test_protocol_error();
`ifdef BRAM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
